key_debounce_arbiter: RTL and testbench
=======================================

// Module: key_debounce_arbiter
// PURPOSE
//  Front end for the vending-machine control FSM. Synchronises and debounces the raw
//  board buttons and coin switches, and turns each accepted press into a single-cycle pulse.
//  Pulses are serialised so that at most one key event reaches the FSM per clock.
//  Output key_pulse drives sys_Goods/Confirm/Change/Cancel and in_money_* directly.
// PARAMETERS
//  N_KEYS           9          number of key channels
//  DEBOUNCE_CYCLES  2_000_000  stable cycles to accept a level change (20 ms @100 MHz); bench uses 4
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//  sys_clk      in   1       system clock, single clock domain
//  sys_rst      in   1       synchronous reset, active-high
//  key_raw      in   N_KEYS  raw asynchronous key/switch levels, 1 = pressed
//  key_pulse    out  N_KEYS  one-hot or zero; one-cycle press event per accepted press
//  key_level    out  N_KEYS  debounced level per channel
//  key_overrun  out  1       one-cycle flag: a press merged into an unserved pending press
// BEHAVIOUR
//  Channel map: 0 Goods, 1 Confirm, 2 Change, 3 Cancel, 4 one, 5 five, 6 ten, 7 twenty, 8 fifty.
//  Reset (sys_rst=1 at an edge): key_pulse=0, key_level=0, key_overrun=0, pending=0,
//   sync FFs=0, counters=0, every channel FSM -> INIT. Reset mid-operation drops all pending presses.
//  Per channel: 2-FF synchroniser -> s; debounce FSM with counter cnt:
//   INIT: needs DEBOUNCE_CYCLES consecutive s=0 -> IDLE; s=1 clears cnt. Key held
//         through reset is ignored until released and stable low; no pulse.
//   IDLE (level 0): s=1 -> PRESS_WAIT, cnt=1.
//   PRESS_WAIT: s=1 increments cnt; s=0 -> IDLE, cnt=0 (bounce);
//         cnt reaching DEBOUNCE_CYCLES -> PRESSED, key_level=1, pending bit set.
//   PRESSED (level 1): s=0 -> RELEASE_WAIT, cnt=1.
//   RELEASE_WAIT: s=0 increments cnt; s=1 -> PRESSED, cnt=0;
//         cnt reaching DEBOUNCE_CYCLES -> IDLE, key_level=0. Release produces no pulse.
//  Latency: raw held high from sampling edge E: key_level rises and pending sets at
//   edge E+DEBOUNCE_CYCLES+2; with no contention key_pulse is high for exactly the one
//   cycle following edge E+DEBOUNCE_CYCLES+3. Release latency of key_level is identical.
//  Arbiter: each edge, if pending!=0, key_pulse <= one-hot of lowest-index pending bit,
//   that bit cleared; else key_pulse <= 0. Fixed priority, never more than one bit set.
//  Contention: simultaneous accepts are all stored; served in index order on consecutive
//   cycles; no press lost unless overrun.
//  Same-edge set and serve of one channel: pending stays 1 (new press kept).
//  Accept on channel whose pending bit is already 1 and not served that edge: merge
//   (bit stays 1), key_overrun=1 for one cycle.
//  cnt saturates at DEBOUNCE_CYCLES; no wrap-around.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 Reset 3 cycles, raw=0 for 10 cycles, raise raw[1] and hold -> key_level[1] at edge
//    E+6, key_pulse=9'h002 for one cycle after E+7, nothing further while held or on release.
//  2 raw[4] toggles 1,0,1,1,0 (bounce shorter than 4) then held -> single pulse 9'h010, only
//    after 4 stable-high synced cycles; release with 2-cycle glitch high -> no pulse.
//  3 raw[1] and raw[5] rise on same edge -> key_pulse 9'h002 then 9'h020 on next cycle.
//  4 raw[8] held high through and after reset -> no pulse; release, stable 4, press -> 9'h100.
//  5 Channels 0,2,3 accepted same edge, sys_rst asserted at next edge -> all pending cleared,
//    key_pulse=0, key_level=0 the cycle after.
//  6 raw all 9 rise together -> 9 consecutive one-hot pulses 0x001..0x100, key_overrun stays 0.

Source files
------------

// File: rtl/key_debounce_arbiter.sv
// Key front end for the vending-machine controller.
// Each raw button or coin switch is synchronised and then debounced. Every accepted
// press becomes a single-cycle pulse. A fixed-priority arbiter serialises the pulses
// so that at most one key event reaches the control FSM on any clock.
// Channel map: 0 Goods, 1 Confirm, 2 Change, 3 Cancel, 4 one, 5 five, 6 ten,
// 7 twenty, 8 fifty.

module key_debounce_arbiter #(
  parameter int unsigned N_KEYS          = 9,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_pulse,
  output logic [N_KEYS-1:0] key_level,
  output logic              key_overrun
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } key_state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Two-stage synchroniser; sync2_q is the clean sample seen by the debouncers.
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;

  // Per-channel debounce state and stability counter.
  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] accept;

  // Arbiter state: presses that have been accepted but not yet forwarded.
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] serve;
  logic [N_KEYS-1:0] pulse_q, pulse_d;
  logic              overrun_q, overrun_d;

  // Synchroniser next state.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
  end

  // Debounce next state for every channel. The counter saturates at CntMax: once the
  // limit is reached, the next sample either commits the level or restarts the count.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      accept[i]  = 1'b0;
      unique case (state_q[i])
        // A key held through reset must be seen released and stable before it arms.
        StInit: begin
          if (sync2_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] >= CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StIdle: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntOne;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CntMax) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            accept[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = CntOne;
          end
        end
        // A release produces no pulse; only the debounced level falls.
        StReleaseWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CntMax) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: begin
          state_d[i] = StInit;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Fixed-priority arbiter: forward the lowest pending press. A fresh accept on the
  // channel being served is kept as a new press; an accept on a channel that is
  // still waiting merges into it and is flagged as an overrun.
  always_comb begin
    serve     = pending_q & (~pending_q + N_KEYS'(1));
    pending_d = (pending_q & ~serve) | accept;
    overrun_d = |(accept & pending_q & ~serve);
    pulse_d   = serve;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= StInit;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign key_pulse   = pulse_q;
  assign key_level   = level_q;
  assign key_overrun = overrun_q;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Bench for key_debounce_arbiter: directed scenarios followed by random bouncing keys,
// with every output checked each cycle against a run-length reference model.

module tb_key_debounce_arbiter;

  localparam int N = 9;
  localparam int D = 4;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_pulse;
  logic [N-1:0] key_level;
  logic         key_overrun;

  key_debounce_arbiter #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_raw    (key_raw),
    .key_pulse  (key_pulse),
    .key_level  (key_level),
    .key_overrun(key_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [N-1:0] m_sync1 = '0;
  logic [N-1:0] m_sync2 = '0;
  logic [N-1:0] m_armed = '0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_pulse = '0;
  logic         m_ovr = 1'b0;
  int           m_run [N];

  // Pulses seen during a scenario.
  logic [N-1:0] seen_q [$];
  bit           recording = 1'b0;
  bit           any_ovr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // The level of a channel flips on the (D+1)th consecutive synced sample that
  // disagrees with it. After reset a channel arms only after D+1 consecutive low
  // samples. Pending presses are served lowest index first, one per clock.
  task automatic model_update();
    logic [N-1:0] s;
    logic [N-1:0] acc;
    int           srv;
    if (sys_rst) begin
      m_sync1   = '0;
      m_sync2   = '0;
      m_armed   = '0;
      m_level   = '0;
      m_pending = '0;
      m_pulse   = '0;
      m_ovr     = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      s       = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = key_raw;
      acc     = '0;
      for (int i = 0; i < N; i++) begin
        if (!m_armed[i]) begin
          if (!s[i]) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
              m_armed[i] = 1'b1;
              m_run[i]   = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_level[i] = s[i];
            m_run[i]   = 0;
            if (s[i]) acc[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      srv = -1;
      for (int i = 0; i < N; i++) begin
        if (m_pending[i] && srv < 0) srv = i;
      end
      m_pulse = '0;
      if (srv >= 0) begin
        m_pulse[srv]   = 1'b1;
        m_pending[srv] = 1'b0;
      end
      m_ovr     = |(acc & m_pending);
      m_pending = m_pending | acc;
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic rst);
    @(negedge sys_clk);
    key_raw = raw;
    sys_rst = rst;
    @(posedge sys_clk);
    model_update();
    #1;
    check_eq("key_level", 32'(key_level), 32'(m_level));
    check_eq("key_pulse", 32'(key_pulse), 32'(m_pulse));
    check_eq("key_overrun", 32'(key_overrun), 32'(m_ovr));
    check_eq("pulse_onehot0", 32'($onehot0(key_pulse)), 32'd1);
    if (recording && key_pulse != '0) seen_q.push_back(key_pulse);
    if (recording && key_overrun) any_ovr = 1'b1;
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    repeat (n) step(raw, 1'b0);
  endtask

  task automatic start_rec();
    seen_q.delete();
    any_ovr   = 1'b0;
    recording = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic         rst;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    key_raw = '0;
    sys_rst = 1'b1;

    // 1: reset, settle, single press on Confirm with exact latency.
    repeat (3) step('0, 1'b1);
    check_eq("rst_level", 32'(key_level), 32'd0);
    check_eq("rst_pulse", 32'(key_pulse), 32'd0);
    hold('0, 10);
    start_rec();
    hold(9'h002, 6);
    check_eq("s1_level_early", 32'(key_level), 32'd0);
    step(9'h002, 1'b0);
    check_eq("s1_level_rise", 32'(key_level), 32'h002);
    check_eq("s1_pulse_early", 32'(key_pulse), 32'd0);
    step(9'h002, 1'b0);
    check_eq("s1_pulse", 32'(key_pulse), 32'h002);
    step(9'h002, 1'b0);
    check_eq("s1_pulse_end", 32'(key_pulse), 32'd0);
    hold(9'h002, 6);
    hold('0, 15);
    recording = 1'b0;
    check_eq("s1_npulse", 32'(seen_q.size()), 32'd1);

    // 2: bouncing press on "one", then release with a short glitch.
    start_rec();
    step(9'h010, 1'b0);
    step(9'h000, 1'b0);
    step(9'h010, 1'b0);
    step(9'h010, 1'b0);
    step(9'h000, 1'b0);
    hold(9'h010, 12);
    hold(9'h000, 2);
    hold(9'h010, 2);
    hold(9'h000, 15);
    recording = 1'b0;
    check_eq("s2_npulse", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() > 0) check_eq("s2_pulse", 32'(seen_q[0]), 32'h010);

    // 3: Confirm and "five" together, served in index order.
    start_rec();
    hold(9'h022, 15);
    hold('0, 15);
    recording = 1'b0;
    check_eq("s3_npulse", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      check_eq("s3_first", 32'(seen_q[0]), 32'h002);
      check_eq("s3_second", 32'(seen_q[1]), 32'h020);
    end

    // 4: "fifty" held through reset is ignored until released.
    hold(9'h100, 3);
    repeat (3) step(9'h100, 1'b1);
    start_rec();
    hold(9'h100, 10);
    hold('0, 15);
    check_eq("s4_no_pulse", 32'(seen_q.size()), 32'd0);
    hold(9'h100, 15);
    hold('0, 15);
    recording = 1'b0;
    check_eq("s4_npulse", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() > 0) check_eq("s4_pulse", 32'(seen_q[0]), 32'h100);

    // 5: three channels accepted, reset on the very next edge drops them.
    hold(9'h00D, 7);
    check_eq("s5_level", 32'(key_level), 32'h00D);
    step(9'h00D, 1'b1);
    check_eq("s5_rst_pulse", 32'(key_pulse), 32'd0);
    check_eq("s5_rst_level", 32'(key_level), 32'd0);
    start_rec();
    hold(9'h00D, 8);
    hold('0, 15);
    recording = 1'b0;
    check_eq("s5_dropped", 32'(seen_q.size()), 32'd0);

    // 6: all keys at once, nine consecutive one-hot pulses.
    start_rec();
    hold(9'h1FF, 20);
    recording = 1'b0;
    check_eq("s6_npulse", 32'(seen_q.size()), 32'd9);
    for (int k = 0; k < 9 && k < seen_q.size(); k++) begin
      check_eq("s6_order", 32'(seen_q[k]), 32'd1 << k);
    end
    check_eq("s6_overrun", 32'(any_ovr), 32'd0);
    hold('0, 20);

    // Random bouncing keys with occasional resets.
    r = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
      end
      rst = ($urandom_range(0, 299) == 0);
      step(r, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
